// File: rtl/lcd_spi_tx_pkg.sv
// Shared definitions for the EADOGS102N-6 LCD SPI byte transmitter.
//  - state_t       : transmitter FSM states
//  - BITS_PER_BYTE : bits shifted per transfer
//  - CD_CMD/CD_DATA: LCD CD pin encodings
//  - cnt_width()   : width of the CS setup/hold counter (never below 1 bit)
package lcd_spi_tx_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_SHIFT = 2'd2,
        ST_HOLD  = 2'd3
    } state_t;

    localparam int   BITS_PER_BYTE = 8;
    localparam logic CD_CMD        = 1'b0;
    localparam logic CD_DATA       = 1'b1;

    // Bits needed to count 0..max(a,b); at least one bit so the counter always exists.
    function automatic int cnt_width(input int a, input int b);
        int m;
        int w;
        m = (a > b) ? a : b;
        w = $clog2(m + 1);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/lcd_spi_tx.sv
// Byte-level SPI mode-0 transmitter for the EADOGS102N-6 LCD.
// Bytes arrive over valid/ready into a one-entry holding register, move into an
// 8-bit shift register and are sent MSB first. The external SCK generator is
// gated by o_sck_en and reports its edges on i_sck_rise / i_sck_fall, which are
// the only timebase used for shifting.
// Ports:
//  i_sysclk, i_sysrst     clock and synchronous active-high reset
//  i_valid, i_data, i_cd  upstream byte and its CD value; o_ready = holding reg empty
//  o_sck_en               enable to the SCK generator
//  i_sck_rise, i_sck_fall one-cycle SCK edge strobes from the SCK generator
//  o_mosi, o_cs_n, o_cd   LCD pins
//  o_busy                 FSM not idle
//  o_done                 one-cycle pulse per byte fully shifted out
module lcd_spi_tx
    import lcd_spi_tx_pkg::*;
#(
    parameter int CS_SETUP_CYC = 2,
    parameter int CS_HOLD_CYC  = 2
) (
    input  logic       i_sysclk,
    input  logic       i_sysrst,
    input  logic       i_valid,
    input  logic [7:0] i_data,
    input  logic       i_cd,
    output logic       o_ready,
    output logic       o_sck_en,
    input  logic       i_sck_rise,
    input  logic       i_sck_fall,
    output logic       o_mosi,
    output logic       o_cs_n,
    output logic       o_cd,
    output logic       o_busy,
    output logic       o_done
);

    localparam int CW           = cnt_width(CS_SETUP_CYC, CS_HOLD_CYC);
    localparam int SETUP_LAST_I = (CS_SETUP_CYC > 0) ? CS_SETUP_CYC - 1 : 0;
    localparam int HOLD_LAST_I  = (CS_HOLD_CYC > 0) ? CS_HOLD_CYC - 1 : 0;
    localparam logic [CW-1:0] SETUP_LAST = SETUP_LAST_I[CW-1:0];
    localparam logic [CW-1:0] HOLD_LAST  = HOLD_LAST_I[CW-1:0];
    localparam logic [CW-1:0] CNT_ZERO   = CW'(1'b0);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1'b1);
    localparam logic [3:0]    BITS_4     = 4'(BITS_PER_BYTE);

    state_t          r_state;
    logic            r_hold_full;
    logic            r_hold_cd;
    logic [7:0]      r_hold_data;
    logic [7:0]      r_shift;
    logic [3:0]      r_bitcnt;
    logic [CW-1:0]   r_cnt;
    logic            r_cs_n;
    logic            r_cd;
    logic            r_sck_en;
    logic            r_mosi;
    logic            r_busy;
    logic            r_done;
    logic            r_ready;

    state_t          w_state_nxt;
    logic            w_accept;
    logic            w_load;
    logic            w_hold_full_nxt;
    logic            w_hold_cd_nxt;
    logic [7:0]      w_hold_data_nxt;
    logic [7:0]      w_shift_nxt;
    logic [3:0]      w_bitcnt_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic            w_cs_n_nxt;
    logic            w_cd_nxt;
    logic            w_sck_en_nxt;
    logic            w_mosi_nxt;
    logic            w_busy_nxt;
    logic            w_done_nxt;

    // Next-state and next-output logic for the transfer FSM and its datapath.
    always_comb begin
        w_state_nxt  = r_state;
        w_load       = 1'b0;
        w_shift_nxt  = r_shift;
        w_bitcnt_nxt = r_bitcnt;
        w_cnt_nxt    = r_cnt;
        w_cs_n_nxt   = r_cs_n;
        w_cd_nxt     = r_cd;
        w_sck_en_nxt = r_sck_en;
        w_done_nxt   = 1'b0;
        w_accept     = i_valid & ~r_hold_full;

        case (r_state)
            ST_IDLE: begin
                w_sck_en_nxt = 1'b0;
                w_cs_n_nxt   = 1'b1;
                if (r_hold_full) begin
                    w_load       = 1'b1;
                    w_shift_nxt  = r_hold_data;
                    w_cd_nxt     = r_hold_cd;
                    w_cs_n_nxt   = 1'b0;
                    w_bitcnt_nxt = 4'd0;
                    w_cnt_nxt    = CNT_ZERO;
                    if (CS_SETUP_CYC > 0) begin
                        w_state_nxt = ST_SETUP;
                    end else begin
                        // SCK enable follows one cycle later from SHIFT itself.
                        w_state_nxt = ST_SHIFT;
                    end
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_SETUP: begin
                if (r_cnt == SETUP_LAST) begin
                    w_state_nxt  = ST_SHIFT;
                    w_sck_en_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            ST_SHIFT: begin
                w_sck_en_nxt = 1'b1;
                if (i_sck_rise) begin
                    // A coincident fall strobe is deliberately dropped.
                    w_bitcnt_nxt = r_bitcnt + 4'd1;
                end else if (i_sck_fall) begin
                    if (r_bitcnt < BITS_4) begin
                        w_shift_nxt = {r_shift[6:0], 1'b0};
                    end else begin
                        w_done_nxt = 1'b1;
                        if (r_hold_full) begin
                            // SCK is low here, so CD may change for the next byte.
                            w_load       = 1'b1;
                            w_shift_nxt  = r_hold_data;
                            w_cd_nxt     = r_hold_cd;
                            w_bitcnt_nxt = 4'd0;
                        end else begin
                            w_sck_en_nxt = 1'b0;
                            w_cnt_nxt    = CNT_ZERO;
                            if (CS_HOLD_CYC > 0) begin
                                w_state_nxt = ST_HOLD;
                            end else begin
                                w_state_nxt = ST_IDLE;
                                w_cs_n_nxt  = 1'b1;
                            end
                        end
                    end
                end else begin
                    w_bitcnt_nxt = r_bitcnt;
                end
            end
            ST_HOLD: begin
                w_sck_en_nxt = 1'b0;
                if (r_cnt == HOLD_LAST) begin
                    w_state_nxt = ST_IDLE;
                    w_cs_n_nxt  = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_cs_n_nxt   = 1'b1;
                w_sck_en_nxt = 1'b0;
            end
        endcase

        // Holding register: fill on accept, empty on transfer to the shift register.
        w_hold_full_nxt = w_accept | (r_hold_full & ~w_load);
        if (w_accept) begin
            w_hold_data_nxt = i_data;
            w_hold_cd_nxt   = i_cd;
        end else begin
            w_hold_data_nxt = r_hold_data;
            w_hold_cd_nxt   = r_hold_cd;
        end

        w_mosi_nxt = (w_state_nxt == ST_IDLE) ? 1'b0 : w_shift_nxt[7];
        w_busy_nxt = (w_state_nxt != ST_IDLE);
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_sysclk) begin
        if (i_sysrst) begin
            r_state     <= ST_IDLE;
            r_hold_full <= 1'b0;
            r_hold_cd   <= CD_CMD;
            r_hold_data <= 8'h00;
            r_shift     <= 8'h00;
            r_bitcnt    <= 4'd0;
            r_cnt       <= CNT_ZERO;
            r_cs_n      <= 1'b1;
            r_cd        <= CD_CMD;
            r_sck_en    <= 1'b0;
            r_mosi      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_ready     <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_hold_full <= w_hold_full_nxt;
            r_hold_cd   <= w_hold_cd_nxt;
            r_hold_data <= w_hold_data_nxt;
            r_shift     <= w_shift_nxt;
            r_bitcnt    <= w_bitcnt_nxt;
            r_cnt       <= w_cnt_nxt;
            r_cs_n      <= w_cs_n_nxt;
            r_cd        <= w_cd_nxt;
            r_sck_en    <= w_sck_en_nxt;
            r_mosi      <= w_mosi_nxt;
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_ready     <= ~w_hold_full_nxt;
        end
    end

    assign o_ready  = r_ready;
    assign o_sck_en = r_sck_en;
    assign o_mosi   = r_mosi;
    assign o_cs_n   = r_cs_n;
    assign o_cd     = r_cd;
    assign o_busy   = r_busy;
    assign o_done   = r_done;

endmodule

// File: tb/tb_lcd_spi_tx.sv
// Bench for lcd_spi_tx: instance 0 uses CS setup/hold of 2 cycles, instance 1
// uses 0/0. A behavioural SCK generator (half-period of 2 sysclk cycles) sits
// beside each instance; an LCD-side monitor records the MOSI/CD value at every
// SCK rising edge and compares against the expected MSB-first bit stream.
module tb_lcd_spi_tx;
    import lcd_spi_tx_pkg::*;

    localparam int BAUD = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       valid [2];
    logic [7:0] data  [2];
    logic       cdin  [2];
    logic       ready [2];
    logic       sck_en[2];
    logic       mosi  [2];
    logic       cs_n  [2];
    logic       cd    [2];
    logic       busy  [2];
    logic       done  [2];

    bit sck [2];
    bit rise[2];
    bit fall[2];
    int div [2];

    int tests = 0;
    int fails = 0;
    int cyc   = 0;

    // LCD-side observations
    bit obs_bit[2][1024];
    bit obs_cd [2][1024];
    int obs_n[2], done_n[2], viol[2], cs_rise_n[2];
    int t_fall[2], t_cs_high[2], t_cs_low[2], t_en_high[2], hi_gap[2];
    bit sck_prev[2], cs_prev[2], en_prev[2], cd_prev[2];

    // Expected stream and per-scenario baselines
    bit exp_bit[2][1024];
    bit exp_cd [2][1024];
    int exp_n[2], obs_base[2], done_base[2], csr_base[2], viol_base[2];

    always #5 clk = ~clk;

    lcd_spi_tx #(.CS_SETUP_CYC(2), .CS_HOLD_CYC(2)) u_dut0 (
        .i_sysclk(clk), .i_sysrst(rst), .i_valid(valid[0]), .i_data(data[0]),
        .i_cd(cdin[0]), .o_ready(ready[0]), .o_sck_en(sck_en[0]),
        .i_sck_rise(rise[0]), .i_sck_fall(fall[0]), .o_mosi(mosi[0]),
        .o_cs_n(cs_n[0]), .o_cd(cd[0]), .o_busy(busy[0]), .o_done(done[0])
    );

    lcd_spi_tx #(.CS_SETUP_CYC(0), .CS_HOLD_CYC(0)) u_dut1 (
        .i_sysclk(clk), .i_sysrst(rst), .i_valid(valid[1]), .i_data(data[1]),
        .i_cd(cdin[1]), .o_ready(ready[1]), .o_sck_en(sck_en[1]),
        .i_sck_rise(rise[1]), .i_sck_fall(fall[1]), .o_mosi(mosi[1]),
        .o_cs_n(cs_n[1]), .o_cd(cd[1]), .o_busy(busy[1]), .o_done(done[1])
    );

    // Cycle counter used to time-stamp pin events.
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural SCK generator: idle low, toggles every BAUD cycles while enabled.
    always @(posedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sck_en[k] !== 1'b1) begin
                div[k] <= 0; sck[k] <= 1'b0; rise[k] <= 1'b0; fall[k] <= 1'b0;
            end else begin
                rise[k] <= 1'b0; fall[k] <= 1'b0;
                if (div[k] == BAUD - 1) begin
                    div[k]  <= 0;
                    sck[k]  <= !sck[k];
                    rise[k] <= !sck[k];
                    fall[k] <= sck[k];
                end else begin
                    div[k] <= div[k] + 1;
                end
            end
        end
    end

    // LCD-side monitor, sampled mid-cycle.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (sck[k] && !sck_prev[k]) begin
                if (obs_n[k] < 1024) begin
                    obs_bit[k][obs_n[k]] <= (mosi[k] === 1'b1);
                    obs_cd[k][obs_n[k]]  <= (cd[k] === 1'b1);
                end
                obs_n[k] <= obs_n[k] + 1;
                if (cs_n[k] !== 1'b0) viol[k] <= viol[k] + 1;
            end
            if (sck[k] && ((cd[k] === 1'b1) != cd_prev[k])) viol[k] <= viol[k] + 1;
            if (done[k] === 1'b1) done_n[k] <= done_n[k] + 1;
            if (fall[k]) t_fall[k] <= cyc;
            if (cs_n[k] === 1'b1 && !cs_prev[k]) begin
                t_cs_high[k] <= cyc;
                cs_rise_n[k] <= cs_rise_n[k] + 1;
            end
            if (cs_n[k] === 1'b0 && cs_prev[k]) begin
                t_cs_low[k] <= cyc;
                hi_gap[k]   <= cyc - t_cs_high[k];
            end
            if (sck_en[k] === 1'b1 && !en_prev[k]) t_en_high[k] <= cyc;
            sck_prev[k] <= sck[k];
            cs_prev[k]  <= (cs_n[k] !== 1'b0);
            en_prev[k]  <= (sck_en[k] === 1'b1);
            cd_prev[k]  <= (cd[k] === 1'b1);
        end
    end

    task automatic check(input string tag, input int got, input int exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic mark(input int k);
        obs_base[k]  = obs_n[k];
        exp_n[k]     = 0;
        done_base[k] = done_n[k];
        csr_base[k]  = cs_rise_n[k];
        viol_base[k] = viol[k];
    endtask

    // Offer a byte; junk is driven while o_ready is low and must be ignored.
    task automatic send(input int k, input bit c, input logic [7:0] d);
        int  n = 0;
        bit  ok = 1'b0;
        while (!ok && n < 2000) begin
            @(negedge clk);
            if (ready[k] === 1'b1) begin
                valid[k] = 1'b1; data[k] = d; cdin[k] = c;
                @(posedge clk);
                ok = 1'b1;
            end else begin
                valid[k] = 1'b1; data[k] = 8'($urandom); cdin[k] = 1'($urandom);
                n++;
            end
        end
        check("send_accept_timeout", int'(ok), 1);
        for (int i = 0; i < 8; i++) begin
            exp_bit[k][exp_n[k] + i] = d[7 - i];
            exp_cd[k][exp_n[k] + i]  = c;
        end
        exp_n[k] += 8;
    endtask

    task automatic release_valid(input int k);
        @(negedge clk);
        valid[k] = 1'b0;
    endtask

    task automatic wait_idle(input int k);
        int n = 0;
        int quiet = 0;
        while (quiet < 4 && n < 4000) begin
            @(negedge clk);
            n++;
            if (busy[k] === 1'b0 && ready[k] === 1'b1) quiet++;
            else quiet = 0;
        end
        check("idle_timeout", int'(quiet >= 4), 1);
    endtask

    task automatic wait_en(input int k, input logic v);
        int n = 0;
        while (sck_en[k] !== v && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("sck_en_timeout", int'(sck_en[k] === v), 1);
    endtask

    task automatic check_stream(input int k, input string tag, input int exp_cs_rises);
        int nb;
        int bad = 0;
        nb = obs_n[k] - obs_base[k];
        check({tag, "_nbits"}, nb, exp_n[k]);
        for (int i = 0; i < exp_n[k] && i < nb; i++) begin
            if (obs_bit[k][obs_base[k] + i] != exp_bit[k][i] ||
                obs_cd[k][obs_base[k] + i] != exp_cd[k][i]) bad++;
        end
        check({tag, "_bit_errs"}, bad, 0);
        check({tag, "_done"}, done_n[k] - done_base[k], exp_n[k] / 8);
        check({tag, "_pin_viol"}, viol[k] - viol_base[k], 0);
        check({tag, "_cs_rises"}, cs_rise_n[k] - csr_base[k], exp_cs_rises);
    endtask

    task automatic check_reset_state(input int k, input string tag);
        check({tag, "_cs_n"},   int'(cs_n[k]),   1);
        check({tag, "_sck_en"}, int'(sck_en[k]), 0);
        check({tag, "_ready"},  int'(ready[k]),  1);
        check({tag, "_busy"},   int'(busy[k]),   0);
        check({tag, "_mosi"},   int'(mosi[k]),   0);
        check({tag, "_done"},   int'(done[k]),   0);
    endtask

    // Watchdog: the bench must never hang.
    initial begin
        #5000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0; data[k] = 8'h00; cdin[k] = CD_CMD;
        end
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_state(0, "rst0");
        check_reset_state(1, "rst1");
        check("rst0_cd", int'(cd[0]), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);

        // Single byte 0xA5, command
        mark(0);
        send(0, CD_CMD, 8'hA5);
        release_valid(0);
        check("a5_ready_low_after_accept", int'(ready[0]), 0);
        @(negedge clk);
        check("a5_ready_back_on_load", int'(ready[0]), 1);
        check("a5_cs_low_on_load", int'(cs_n[0]), 0);
        wait_idle(0);
        check_stream(0, "a5", 1);
        check("a5_setup_gap", t_en_high[0] - t_cs_low[0], 2);
        check("a5_hold_gap", t_cs_high[0] - t_fall[0], 3);

        // Back-to-back 0x3C/0xFF/0x00 with valid held
        mark(0);
        send(0, CD_CMD, 8'h3C);
        send(0, CD_DATA, 8'hFF);
        send(0, CD_DATA, 8'h00);
        release_valid(0);
        wait_idle(0);
        check_stream(0, "b2b", 1);
        check("b2b_hold_gap", t_cs_high[0] - t_fall[0], 3);

        // Random back-to-back bytes, junk on i_data while stalled
        mark(0);
        for (int j = 0; j < 4; j++) send(0, 1'($urandom), 8'($urandom));
        release_valid(0);
        wait_idle(0);
        check_stream(0, "rnd_b2b", 1);

        // Byte arriving during CS hold: exactly one cycle of CS high before reload
        mark(0);
        send(0, 1'($urandom), 8'($urandom));
        release_valid(0);
        wait_en(0, 1'b1);
        wait_en(0, 1'b0);
        send(0, 1'($urandom), 8'($urandom));
        release_valid(0);
        wait_idle(0);
        check_stream(0, "hold_reload", 2);
        check("hold_reload_cs_high_gap", hi_gap[0], 1);

        // Reset after the 4th rise of 0x81
        mark(0);
        send(0, CD_CMD, 8'h81);
        release_valid(0);
        n = 0;
        while ((obs_n[0] - obs_base[0]) < 4 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("abort_reach_4th_rise", obs_n[0] - obs_base[0], 4);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check_reset_state(0, "abort");
        rst = 1'b0;
        repeat (20) @(negedge clk);
        check("abort_no_done", done_n[0] - done_base[0], 0);
        mark(0);
        send(0, CD_DATA, 8'h55);
        release_valid(0);
        wait_idle(0);
        check_stream(0, "after_abort", 1);

        // Zero setup/hold build
        mark(1);
        send(1, CD_CMD, 8'h01);
        release_valid(1);
        wait_idle(1);
        check_stream(1, "z01", 1);
        check("z01_setup_gap", t_en_high[1] - t_cs_low[1], 1);
        check("z01_hold_gap", t_cs_high[1] - t_fall[1], 1);
        mark(1);
        send(1, 1'($urandom), 8'($urandom));
        release_valid(1);
        wait_en(1, 1'b1);
        wait_en(1, 1'b0);
        send(1, 1'($urandom), 8'($urandom));
        release_valid(1);
        wait_idle(1);
        check_stream(1, "z_reload", 2);
        check("z_reload_cs_high_min1", int'(hi_gap[1] >= 1), 1);

        // Randomized traffic with random idle gaps on both builds
        for (int k = 0; k < 2; k++) begin
            mark(k);
            n = 0;
            for (int j = 0; j < 8; j++) begin
                send(k, 1'($urandom), 8'($urandom));
                if ($urandom_range(0, 2) == 0) begin
                    n++;
                    release_valid(k);
                    repeat ($urandom_range(0, 15)) @(negedge clk);
                end
            end
            release_valid(k);
            wait_idle(k);
            check_stream(k, (k == 0) ? "rand0" : "rand1", cs_rise_n[k] - csr_base[k]);
            check((k == 0) ? "rand0_cs_rises_min" : "rand1_cs_rises_min",
                  int'((cs_rise_n[k] - csr_base[k]) >= 1 && (cs_rise_n[k] - csr_base[k]) <= n + 1), 1);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
